// File: rtl/reflet_float_mult_norm_pkg.sv
// Shared float format helpers and result flag encodings for the multiplier
// normalise/round datapath.
package reflet_float_mult_norm_pkg;

  function automatic int mantissa_size(input int float_size);
    case (float_size)
      16:      return 10;
      64:      return 52;
      128:     return 112;
      default: return 23;
    endcase
  endfunction

  function automatic int exponent_size(input int float_size);
    case (float_size)
      16:      return 5;
      64:      return 11;
      128:     return 15;
      default: return 8;
    endcase
  endfunction

  function automatic int exponent_bias(input int float_size);
    return (1 << (exponent_size(float_size) - 1)) - 1;
  endfunction

  // {overflow, underflow, inexact}; range exceptions always report inexact
  localparam logic [2:0] FLAGS_NONE      = 3'b000;
  localparam logic [2:0] FLAGS_OVERFLOW  = 3'b101;
  localparam logic [2:0] FLAGS_UNDERFLOW = 3'b011;

endpackage

// File: rtl/reflet_float_round.sv
// Round-to-nearest-even and exponent range check for a normalised significand.
// Purely combinational so the adder datapath can reuse it.
module reflet_float_round
  import reflet_float_mult_norm_pkg::*;
#(
  parameter int float_size = 32,
  localparam int M = mantissa_size(float_size),
  localparam int E = exponent_size(float_size)
) (
  input  logic                  sign,
  input  logic [E+1:0]          exponent,
  input  logic [M-1:0]          mantissa,
  input  logic                  guard,
  input  logic                  sticky,
  input  logic                  zero,
  output logic [float_size-1:0] result,
  output logic [2:0]            flags
);

  localparam logic [E:0] EXP_INF = (E+1)'((1 << E) - 1);

  logic         round_up;
  logic         inexact;
  logic [M:0]   mnt_sum;
  logic [E+1:0] exp_rnd;
  logic         exp_over;
  logic         exp_under;

  always_comb begin
    round_up = guard && (sticky || mantissa[0]);
    inexact  = guard || sticky;
    mnt_sum  = {1'b0, mantissa} + {{M{1'b0}}, round_up};
    // A carry out of the mantissa leaves the low bits all zero already
    exp_rnd  = exponent + {{(E+1){1'b0}}, mnt_sum[M]};
    exp_over  = !exp_rnd[E+1] && (exp_rnd[E:0] >= EXP_INF);
    exp_under = exp_rnd[E+1] || (exp_rnd == '0);

    result = {sign, exp_rnd[E-1:0], mnt_sum[M-1:0]};
    flags  = {2'b00, inexact};
    if (zero) begin
      result = {sign, {(float_size-1){1'b0}}};
      flags  = FLAGS_NONE;
    end else if (exp_over) begin
      result = {sign, {E{1'b1}}, {M{1'b0}}};
      flags  = FLAGS_OVERFLOW;
    end else if (exp_under) begin
      result = {sign, {(float_size-1){1'b0}}};
      flags  = FLAGS_UNDERFLOW;
    end
  end

endmodule

// File: rtl/reflet_float_mult_norm.sv
// Two-stage normalise-and-round stage behind the float multiplier: stage 1
// normalises the raw significand product, stage 2 registers the rounded result.
module reflet_float_mult_norm
  import reflet_float_mult_norm_pkg::*;
#(
  parameter int float_size = 32,
  localparam int M = mantissa_size(float_size),
  localparam int E = exponent_size(float_size)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [E+1:0]          in_exp,
  input  logic [2*M+1:0]        in_mnt,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [float_size-1:0] out_float,
  output logic [2:0]            out_flags
);

  logic                  v1_reg, v2_reg;
  logic                  en1, en2;

  logic [E+1:0]          exp_norm;
  logic [M-1:0]          mnt_norm;
  logic                  guard_norm, sticky_norm;

  logic                  sign1_reg, guard1_reg, sticky1_reg, zero1_reg;
  logic [E+1:0]          exp1_reg;
  logic [M-1:0]          mnt1_reg;

  logic [float_size-1:0] float_next, float_reg;
  logic [2:0]            flags_next, flags_reg;

  assign en2      = !v2_reg || out_ready;
  assign en1      = !v1_reg || en2;
  assign in_ready = en1;

  // Product of two [1,2) significands lies in [1,4); bit 2M+1 marks the upper half
  always_comb begin
    if (in_mnt[2*M+1]) begin
      mnt_norm    = in_mnt[2*M:M+1];
      guard_norm  = in_mnt[M];
      sticky_norm = |in_mnt[M-1:0];
      exp_norm    = in_exp + {{(E+1){1'b0}}, 1'b1};
    end else begin
      mnt_norm    = in_mnt[2*M-1:M];
      guard_norm  = in_mnt[M-1];
      sticky_norm = |in_mnt[M-2:0];
      exp_norm    = in_exp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg      <= 1'b0;
      sign1_reg   <= 1'b0;
      exp1_reg    <= '0;
      mnt1_reg    <= '0;
      guard1_reg  <= 1'b0;
      sticky1_reg <= 1'b0;
      zero1_reg   <= 1'b0;
    end else if (en1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        sign1_reg   <= in_sign;
        exp1_reg    <= exp_norm;
        mnt1_reg    <= mnt_norm;
        guard1_reg  <= guard_norm;
        sticky1_reg <= sticky_norm;
        zero1_reg   <= in_zero;
      end
    end
  end

  reflet_float_round #(
    .float_size(float_size)
  ) u_round (
    .sign     (sign1_reg),
    .exponent (exp1_reg),
    .mantissa (mnt1_reg),
    .guard    (guard1_reg),
    .sticky   (sticky1_reg),
    .zero     (zero1_reg),
    .result   (float_next),
    .flags    (flags_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_reg    <= 1'b0;
      float_reg <= '0;
      flags_reg <= FLAGS_NONE;
    end else if (en2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        float_reg <= float_next;
        flags_reg <= flags_next;
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_float = float_reg;
  assign out_flags = flags_reg;

endmodule
